// File: rtl/ext_mem_responder.sv
// ext_mem_responder: behavioural external-memory responder.
// Accepts one-cycle read/write request pulses and answers each with a
// single-cycle ready pulse LATENCY+1 cycles after the request. It keeps a
// word-addressed backing store and counts completed reads, completed
// writes and error events (out-of-range accesses and dropped requests).
module ext_mem_responder #(
    parameter int unsigned ADDR_WID = 14,
    parameter int unsigned LATENCY  = 4,
    parameter logic [63:0] BASE     = 64'h0,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [63:0] read_addr,
    input  logic [63:0] read_size,
    input  logic        write_enable,
    input  logic [63:0] write_addr,
    input  logic [31:0] write_data,
    output logic [63:0] read_ready,
    output logic [31:0] read_data,
    output logic [63:0] write_ready,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] err_count,
    output logic        busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] WR_WAIT = 3'd2;
    localparam logic [2:0] RD_RESP = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    localparam int unsigned DEPTH    = 1 << ADDR_WID;
    localparam logic [7:0]  LAT_LOAD = 8'(LATENCY - 1);

    logic [31:0]         mem [DEPTH];

    logic [2:0]          state;
    logic [7:0]          cnt;
    logic [ADDR_WID-1:0] cur_idx;
    logic                cur_err;
    logic [31:0]         cur_wdata;
    logic                pend_valid;
    logic [ADDR_WID-1:0] pend_idx;
    logic                pend_err;
    logic [63:0]         size_q;

    logic [63:0]         rd_off;
    logic [63:0]         wr_off;
    logic                rd_oor;
    logic                wr_oor;
    logic [ADDR_WID-1:0] rd_idx;
    logic [ADDR_WID-1:0] wr_idx;
    logic [1:0]          drop_n;
    logic                resp_err;
    logic                unused_bits;

    // Byte address -> word index; anything below BASE or past the store is out of range.
    always_comb begin
        rd_off = read_addr - BASE;
        wr_off = write_addr - BASE;
        rd_oor = (read_addr < BASE) || (rd_off[63:ADDR_WID+2] != '0);
        wr_oor = (write_addr < BASE) || (wr_off[63:ADDR_WID+2] != '0);
        rd_idx = rd_off[ADDR_WID+1:2];
        wr_idx = wr_off[ADDR_WID+1:2];
    end

    // Error events this cycle: requests arriving outside IDLE plus an out-of-range completion.
    always_comb begin
        drop_n   = '0;
        resp_err = 1'b0;
        if (state != IDLE) begin
            drop_n = {1'b0, read_enable} + {1'b0, write_enable};
        end
        if ((state == RD_RESP) || (state == WR_RESP)) begin
            resp_err = cur_err;
        end
    end

    // Request sequencing, latency countdown, read data capture and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_idx    <= '0;
            cur_err    <= 1'b0;
            cur_wdata  <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_err   <= 1'b0;
            size_q     <= '0;
            read_data  <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
            err_count  <= '0;
        end else begin
            err_count <= err_count + 32'(drop_n) + 32'(resp_err);
            case (state)
                IDLE: begin
                    if (read_enable) begin
                        size_q <= read_size;
                    end
                    if (write_enable) begin
                        // Write goes first; a simultaneous read waits in the pending slot.
                        state     <= WR_WAIT;
                        cnt       <= LAT_LOAD;
                        cur_idx   <= wr_idx;
                        cur_err   <= wr_oor;
                        cur_wdata <= write_data;
                        if (read_enable) begin
                            pend_valid <= 1'b1;
                            pend_idx   <= rd_idx;
                            pend_err   <= rd_oor;
                        end
                    end else if (read_enable) begin
                        state   <= RD_WAIT;
                        cnt     <= LAT_LOAD;
                        cur_idx <= rd_idx;
                        cur_err <= rd_oor;
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        state     <= RD_RESP;
                        read_data <= cur_err ? ERR_DATA : mem[cur_idx];
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        state <= WR_RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RD_RESP, WR_RESP: begin
                    if (state == RD_RESP) begin
                        rd_count <= rd_count + 32'd1;
                    end else begin
                        wr_count <= wr_count + 32'd1;
                    end
                    if (pend_valid) begin
                        state      <= RD_WAIT;
                        cnt        <= LAT_LOAD;
                        cur_idx    <= pend_idx;
                        cur_err    <= pend_err;
                        pend_valid <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store commit at the end of WR_RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if ((state == WR_RESP) && !cur_err) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign read_ready  = {63'd0, (state == RD_RESP)};
    assign write_ready = {63'd0, (state == WR_RESP)};
    assign busy        = (state != IDLE) || pend_valid;

    // read_size is recorded only; low address bits are don't-care.
    assign unused_bits = ^{size_q, rd_off[1:0], wr_off[1:0]};

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder. A transaction-level model
// predicts, per request, the edge on which the ready pulse appears, when
// the responder is free again, the store contents and all counters.
module tb_ext_mem_responder;

    localparam int          AW    = 6;
    localparam int          LAT   = 4;
    localparam int          WORDS = 1 << AW;
    localparam logic [63:0] BASE  = 64'h1000;
    localparam logic [31:0] ERRD  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_enable = 1'b0, write_enable = 1'b0;
    logic [63:0] read_addr = '0, read_size = '0, write_addr = '0;
    logic [31:0] write_data = '0;
    logic [63:0] read_ready, write_ready;
    logic [31:0] read_data, rd_count, wr_count, err_count;
    logic        busy;

    logic        b_read_enable = 1'b0, b_write_enable = 1'b0;
    logic [63:0] b_read_addr = '0, b_read_size = '0, b_write_addr = '0;
    logic [31:0] b_write_data = '0;
    logic [63:0] b_read_ready, b_write_ready;
    logic [31:0] b_read_data, b_rd_count, b_wr_count, b_err_count;
    logic        b_busy;

    always #5 clk = ~clk;

    ext_mem_responder #(.ADDR_WID(AW), .LATENCY(LAT), .BASE(BASE), .ERR_DATA(ERRD)) dut (
        .clk(clk), .reset(reset),
        .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .read_ready(read_ready), .read_data(read_data), .write_ready(write_ready),
        .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count), .busy(busy)
    );

    ext_mem_responder #(.ADDR_WID(AW), .LATENCY(1), .BASE(BASE), .ERR_DATA(ERRD)) dut1 (
        .clk(clk), .reset(reset),
        .read_enable(b_read_enable), .read_addr(b_read_addr), .read_size(b_read_size),
        .write_enable(b_write_enable), .write_addr(b_write_addr), .write_data(b_write_data),
        .read_ready(b_read_ready), .read_data(b_read_data), .write_ready(b_write_ready),
        .rd_count(b_rd_count), .wr_count(b_wr_count), .err_count(b_err_count), .busy(b_busy)
    );

    // Reference model state: edge numbers of expected ready pulses and first free edge.
    int          k = 0;
    int          accept_ok = 0;
    int          rd_edge = -100, wr_edge = -100;
    bit          rd_oor, wr_oor;
    int          rd_idx_m, wr_idx_m;
    logic [31:0] wr_data_m;
    logic [31:0] ref_mem [WORDS];
    logic [31:0] ref_rdata = '0, ref_rd = '0, ref_wr = '0, ref_err = '0;
    int          errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    function automatic void decode(input logic [63:0] a, output bit oor, output int idx);
        logic [63:0] off;
        off = a - BASE;
        oor = (a < BASE) || ((off >> 2) >= 64'(WORDS));
        idx = oor ? 0 : int'(off[31:0] >> 2);
    endfunction

    function automatic logic [63:0] rand_addr();
        int m;
        m = $urandom_range(0, 9);
        if (m == 0) return BASE - 64'($urandom_range(1, 4096));
        if (m == 1) return BASE + 64'(WORDS * 4) + 64'($urandom_range(0, 100000));
        if (m == 2) return {$urandom, $urandom};
        return BASE + 64'($urandom_range(0, WORDS * 4 - 1));
    endfunction

    task automatic model_clear();
        rd_edge   = -100;
        wr_edge   = -100;
        accept_ok = 0;
        ref_rd    = '0;
        ref_wr    = '0;
        ref_err   = '0;
        ref_rdata = '0;
    endtask

    // One clock: present a request, advance the model, compare every output.
    task automatic step(input bit re, input logic [63:0] ra, input bit we,
                        input logic [63:0] wa, input logic [31:0] wd);
        read_enable  = re;
        read_addr    = ra;
        read_size    = {$urandom, $urandom};
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        @(posedge clk);
        k++;
        #1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        if (rd_edge == k - 1) begin
            ref_rd++;
            if (rd_oor) ref_err++;
            rd_edge = -100;
        end
        if (wr_edge == k - 1) begin
            ref_wr++;
            if (wr_oor) ref_err++;
            else ref_mem[wr_idx_m] = wr_data_m;
            wr_edge = -100;
        end
        if (re || we) begin
            if (k >= accept_ok) begin
                if (we) begin
                    decode(wa, wr_oor, wr_idx_m);
                    wr_data_m = wd;
                    wr_edge   = k + LAT;
                end
                if (re) begin
                    decode(ra, rd_oor, rd_idx_m);
                    rd_edge = we ? k + 2 * LAT + 1 : k + LAT;
                end
                accept_ok = (re && we) ? k + 2 * LAT + 3 : k + LAT + 2;
            end else begin
                ref_err += 32'(int'(re) + int'(we));
            end
        end
        if (k == rd_edge) ref_rdata = rd_oor ? ERRD : ref_mem[rd_idx_m];
        chk("read_ready", read_ready, 64'(k == rd_edge));
        chk("write_ready", write_ready, 64'(k == wr_edge));
        chk("read_data", 64'(read_data), 64'(ref_rdata));
        chk("rd_count", 64'(rd_count), 64'(ref_rd));
        chk("wr_count", 64'(wr_count), 64'(ref_wr));
        chk("err_count", 64'(err_count), 64'(ref_err));
        chk("busy", 64'(busy), 64'(k <= accept_ok - 2));
    endtask

    task automatic idle1();
        step(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((k + 1 < accept_ok) && (guard < 100)) begin
            idle1();
            guard++;
        end
        chk("wait_idle_bound", 64'(k + 1 >= accept_ok), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_clear();
        chk("rst_read_ready", read_ready, '0);
        chk("rst_write_ready", write_ready, '0);
        chk("rst_read_data", 64'(read_data), '0);
        chk("rst_rd_count", 64'(rd_count), '0);
        chk("rst_wr_count", 64'(wr_count), '0);
        chk("rst_err_count", 64'(err_count), '0);
        chk("rst_busy", 64'(busy), '0);
        @(posedge clk);
        k++;
        @(posedge clk);
        k++;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at edge %0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Fill the store so every later read has a known value.
        for (int i = 0; i < WORDS; i++) begin
            step(1'b0, '0, 1'b1, BASE + 64'(4 * i), $urandom);
            wait_idle();
        end

        do_reset();
        // Write then read the same word, counters from a fresh reset.
        step(1'b0, '0, 1'b1, BASE + 64'd8, 32'h1234);
        wait_idle();
        step(1'b1, BASE + 64'd8, 1'b0, '0, '0);
        wait_idle();
        chk("rd_after_wr", 64'(read_data), 64'h1234);

        // Simultaneous write and read to the same word.
        step(1'b1, BASE, 1'b1, BASE, 32'hA5);
        wait_idle();
        chk("simul_rd_data", 64'(read_data), 64'hA5);

        // Just past the end, just below BASE, last word, unaligned address.
        step(1'b1, BASE + 64'(4 * WORDS), 1'b0, '0, '0);
        wait_idle();
        chk("oor_data", 64'(read_data), 64'(ERRD));
        step(1'b1, BASE - 64'd4, 1'b0, '0, '0);
        wait_idle();
        step(1'b0, '0, 1'b1, BASE + 64'(4 * (WORDS - 1)), 32'hCAFE0001);
        wait_idle();
        step(1'b1, BASE + 64'(4 * (WORDS - 1)) + 64'd3, 1'b0, '0, '0);
        wait_idle();
        step(1'b0, '0, 1'b1, BASE + 64'(4 * WORDS), 32'h0BAD0BAD);
        wait_idle();

        // Second read two cycles after the first is dropped.
        step(1'b1, BASE + 64'h20, 1'b0, '0, '0);
        idle1();
        step(1'b1, BASE + 64'h24, 1'b0, '0, '0);
        wait_idle();

        // Reset aborts an in-flight write; store keeps its prior value.
        step(1'b0, '0, 1'b1, BASE + 64'h10, 32'h55AA55AA);
        idle1();
        do_reset();
        step(1'b1, BASE + 64'h10, 1'b0, '0, '0);
        wait_idle();

        // Random traffic, including requests while busy.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) == 0, rand_addr(), $urandom_range(0, 3) == 0,
                 rand_addr(), $urandom);
        end
        wait_idle();

        // LATENCY=1 instance: reads accepted at edges 0 and 3.
        b_read_enable = 1'b1;
        b_read_addr   = BASE + 64'd4;
        for (int j = 0; j < 7; j++) begin
            @(posedge clk);
            #1;
            b_read_enable = (j == 2);
            b_read_addr   = BASE + 64'(4 * WORDS);
            chk($sformatf("lat1_ready_%0d", j), b_read_ready, 64'(j == 1 || j == 4));
        end
        chk("lat1_rd_count", 64'(b_rd_count), 64'd2);
        chk("lat1_err_count", 64'(b_err_count), 64'd1);
        chk("lat1_read_data", 64'(b_read_data), 64'(ERRD));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_mem_responder.md
EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
REQ-001 Parameter ADDR_WID, default 14, word-address width; backing store holds 2**ADDR_WID 32-bit words.
REQ-002 Parameter LATENCY, default 4, cycles from request accept to ready pulse; legal range 1..255.
REQ-003 Parameter BASE, default 64'h0, byte address mapped to word 0.
REQ-004 Parameter ERR_DATA, default 32'hDEADBEEF, data returned for out-of-range reads.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 read_enable  in  1  one-cycle read request pulse.
REQ-008 read_addr  in  64  byte address of read, valid with read_enable.
REQ-009 read_size  in  64  requested size; recorded only, not used for addressing.
REQ-010 write_enable  in  1  one-cycle write request pulse.
REQ-011 write_addr  in  64  byte address of write, valid with write_enable.
REQ-012 write_data  in  32  write data, valid with write_enable.
REQ-013 read_ready  out  64  value 1 for exactly one cycle when read_data is valid, else 0.
REQ-014 read_data  out  32  read result; held until the next read completes.
REQ-015 write_ready  out  64  value 1 for exactly one cycle when the write is committed, else 0.
REQ-016 rd_count, wr_count, err_count  out  32 each  accepted reads, accepted writes, error events.
REQ-017 busy  out  1  high while a request is pending or in service.

Function
REQ-018 States: IDLE, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP.
REQ-019 IDLE, read_enable only: latch address; go to RD_WAIT; load latency counter with LATENCY-1.
REQ-020 IDLE, write_enable only: latch address and data; go to WR_WAIT; load latency counter with LATENCY-1.
REQ-021 IDLE, both enables in the same cycle: service the write first; latch the read into a one-entry pending slot; service the read after WR_RESP with no idle cycle.
REQ-022 RD_WAIT/WR_WAIT: decrement counter each cycle; at 0, go to RD_RESP/WR_RESP.
REQ-023 RD_RESP: drive read_data and read_ready=1 for one cycle; increment rd_count; then return to IDLE, or start the pending request.
REQ-024 WR_RESP: commit the word to the store; drive write_ready=1 for one cycle; increment wr_count; then return to IDLE, or start the pending read.
REQ-025 Total latency: ready pulse appears exactly LATENCY+1 cycles after the enable cycle (enable at cycle t, ready at t+LATENCY+1).
REQ-026 Word index = (addr - BASE) >> 2, 64-bit unsigned subtract; bits [1:0] of (addr - BASE) ignored.
REQ-027 Out of range (addr < BASE, or index >= 2**ADDR_WID): read returns ERR_DATA; write is not committed; the ready pulse is still issued with normal timing; err_count increments.
REQ-028 Request arriving while busy with the pending slot full, or any request arriving outside IDLE except via the pending slot: drop it, increment err_count, no ready pulse.
REQ-029 Read after write to the same address returns the written data (write committed before any later read is serviced).
REQ-030 Counters wrap modulo 2**32 silently.
REQ-031 busy = (state != IDLE) or pending slot valid.

Reset
REQ-032 While reset=0: state IDLE, read_ready=0, write_ready=0, read_data=0, all counters=0, busy=0, pending slot empty.
REQ-033 Reset asserted mid-operation aborts the in-flight request: no ready pulse, and no store write if reset precedes WR_RESP.
REQ-034 Store contents are not cleared by reset.
REQ-035 First request accepted on the first posedge with reset=1.

Verification
REQ-036 LATENCY=4: write 0x1234 to BASE+8 at cycle 0 -> write_ready=1 at cycle 5 only; read BASE+8 -> read_data=0x1234, read_ready at +5; rd_count=1, wr_count=1.
REQ-037 Simultaneous write 0xA5 and read, both to BASE+0 -> write_ready at +5, read_ready at +10, read_data=0xA5.
REQ-038 Read BASE + 4*2**ADDR_WID -> read_data=0xDEADBEEF, read_ready at +5, err_count=1.
REQ-039 Second read_enable issued 2 cycles after a first read -> first completes normally, second dropped, err_count=1, rd_count=1.
REQ-040 Reset pulled low 2 cycles after a write_enable to BASE+0x10 -> no write_ready; subsequent read of BASE+0x10 returns the prior contents.
REQ-041 LATENCY=1 back-to-back: read enable at cycle 0 and again at cycle 3 -> read_ready at cycles 2 and 5.
